// File: rtl/check_data_scanner.sv
// Scans the debug pipeline stages through the select mux and streams one snapshot word per stage.
// Define CHECK_SCAN_HZD_EN to include the hazard stage (6 words) instead of the 5 pipeline stages.
module check_data_scanner #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] check_data,
  output logic [2:0]        check_addr,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              done
);

  localparam int unsigned IDX_W = 3;
`ifdef CHECK_SCAN_HZD_EN
  localparam logic [IDX_W-1:0] LAST = IDX_W'(5);
`else
  localparam logic [IDX_W-1:0] LAST = IDX_W'(4);
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAP  = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [IDX_W-1:0] check_addr_nxt;
  logic             busy_nxt, out_valid_nxt, done_nxt;

  // Next state plus next values of the registered outputs, all derived from the next state
  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    check_addr_nxt = '0;
    busy_nxt       = 1'b0;
    out_valid_nxt  = 1'b0;
    done_nxt       = 1'b0;

    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_nxt = CAP;
          idx_nxt   = '0;
        end
      end
      CAP: begin
        state_nxt = abort ? IDLE : SEND;
      end
      SEND: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (out_valid && out_ready) begin
          if (idx == LAST) begin
            state_nxt = DONE;
          end else begin
            state_nxt = CAP;
            idx_nxt   = idx + IDX_W'(1);
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt      = (state_nxt != IDLE);
    out_valid_nxt = (state_nxt == SEND);
    done_nxt      = (state_nxt == DONE);
    if (state_nxt == CAP || state_nxt == SEND) begin
      check_addr_nxt = idx_nxt;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      idx        <= '0;
      check_addr <= '0;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      check_addr <= check_addr_nxt;
      busy       <= busy_nxt;
      out_valid  <= out_valid_nxt;
      done       <= done_nxt;
    end
  end

  // Snapshot: the mux output is captured at the edge that leaves CAP and then held while presented
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_addr <= '0;
      out_data <= '0;
    end else if (state == CAP) begin
      out_addr <= idx;
      out_data <= check_data;
    end
  end

endmodule

// File: tb/tb_check_data_scanner.sv
// Directed bench for check_data_scanner: full scans, back-pressure, abort, async reset, ignored starts.
module tb_check_data_scanner;

  localparam int unsigned DATA_W = 32;
`ifdef CHECK_SCAN_HZD_EN
  localparam int unsigned LAST = 5;
`else
  localparam int unsigned LAST = 4;
`endif

  logic              clk = 1'b0;
  logic              rstn;
  logic              start, abort, out_ready;
  logic [DATA_W-1:0] check_data;
  logic [2:0]        check_addr;
  logic              busy, out_valid, done;
  logic [2:0]        out_addr;
  logic [DATA_W-1:0] out_data;
  logic [DATA_W-1:0] base;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  check_data_scanner #(.DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .abort      (abort),
    .check_data (check_data),
    .check_addr (check_addr),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_data   (out_data),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Debug select mux model
  assign check_data = base + DATA_W'(check_addr);

  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  // The stage index must never run past the last configured stage
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      checks++;
      assert (int'(check_addr) <= LAST) else begin
        failures++;
        $error("FAIL check_addr_range observed=%0d expected<=%0d", check_addr, LAST);
      end
    end
  end

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full scan with out_ready held high; starts from IDLE
  task automatic full_scan(input logic [DATA_W-1:0] b, input int exp_done);
    base  = b;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("scan_cap0_busy", busy, 1);
    chk("scan_cap0_valid", out_valid, 0);
    step();
    for (int i = 0; i <= int'(LAST); i++) begin
      chk("scan_valid", out_valid, 1);
      chk("scan_addr", out_addr, DATA_W'(i));
      chk("scan_data", out_data, b + DATA_W'(i));
      chk("scan_check_addr", check_addr, DATA_W'(i));
      step();
      if (i != int'(LAST)) begin
        chk("scan_cap_valid", out_valid, 0);
        chk("scan_cap_check_addr", check_addr, DATA_W'(i + 1));
        chk("scan_cap_done", done, 0);
        step();
      end
    end
    chk("scan_done_pulse", done, 1);
    chk("scan_done_busy", busy, 1);
    chk("scan_done_valid", out_valid, 0);
    chk("scan_done_check_addr", check_addr, 0);
    step();
    chk("scan_idle_done", done, 0);
    chk("scan_idle_busy", busy, 0);
    chk("scan_done_count", DATA_W'(done_cnt), DATA_W'(exp_done));
  endtask

  initial begin
    rstn      = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b1;
    base      = 32'h1000_0000;
    #1 rstn = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_check_addr", check_addr, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    rstn = 1'b1;
    step();
    chk("idle_busy", busy, 0);

    // Full scan, every word accepted immediately
    full_scan(32'h1000_0000, 1);

    // Back-pressure on word 2, with stray start pulses while busy
    base  = 32'h2000_0000;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("bp_addr0", out_addr, 0);
    step();
    step();
    chk("bp_addr1", out_addr, 1);
    step();
    out_ready = 1'b0;
    step();
    for (int c = 0; c < 4; c++) begin
      start = c[0];
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_addr", out_addr, 2);
      chk("bp_hold_data", out_data, 32'h2000_0002);
      chk("bp_hold_busy", busy, 1);
      step();
    end
    start     = 1'b0;
    chk("bp_last_hold_addr", out_addr, 2);
    out_ready = 1'b1;
    step();
    chk("bp_resume_cap3", check_addr, 3);
    chk("bp_resume_valid", out_valid, 0);
    step();
    chk("bp_send3_addr", out_addr, 3);
    chk("bp_send3_data", out_data, 32'h2000_0003);

    // Abort in SEND of addr 3, coinciding with a transfer
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_check_addr", check_addr, 0);
    chk("abort_done", done, 0);
    step();
    chk("abort_idle_busy", busy, 0);
    chk("abort_done_count", DATA_W'(done_cnt), 1);

    // Restart begins again at addr 0
    base  = 32'h3000_0000;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_cap0", check_addr, 0);
    step();
    chk("restart_addr0", out_addr, 0);
    chk("restart_data0", out_data, 32'h3000_0000);
    step();
    chk("restart_cap1", check_addr, 1);

    // Asynchronous reset in the middle of CAP of addr 1
    #2 rstn = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_check_addr", check_addr, 0);
    chk("arst_out_addr", out_addr, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_done", done, 0);
    step();
    #2 rstn = 1'b1;
    step();
    chk("arst_rel_busy", busy, 0);
    chk("arst_rel_valid", out_valid, 0);

    // start and abort together in IDLE
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk("sa_busy", busy, 0);
    chk("sa_valid", out_valid, 0);
    step();
    chk("sa_busy2", busy, 0);
    chk("sa_done_count", DATA_W'(done_cnt), 1);

    // Second complete scan
    full_scan(32'h4000_0000, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/check_data_scanner.md
CHECK_DATA_SCANNER -- requirements
Module: check_data_scanner

Interface
REQ-001 Parameter DATA_W, default 32, width of check/snapshot data.
REQ-002 clk  input  1  single clock; all state rising-edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request one scan of all debug stages.
REQ-005 abort  input  1  terminate a scan in progress.
REQ-006 check_data  input  DATA_W  selected stage data from the debug select mux.
REQ-007 check_addr  output  3  stage index driven to the debug select mux.
REQ-008 busy  output  1  high in any state other than IDLE.
REQ-009 out_valid  output  1  snapshot word available.
REQ-010 out_ready  input  1  consumer accepts the snapshot word.
REQ-011 out_addr  output  3  stage index of the presented word.
REQ-012 out_data  output  DATA_W  captured stage data.
REQ-013 done  output  1  one-cycle pulse after the last word is accepted.

Function
REQ-014 FSM states: IDLE, CAP, SEND, DONE; encoding is free.
REQ-015 IDLE: start=1 and abort=0 -> CAP with idx=0; otherwise stay in IDLE.
REQ-016 CAP: check_addr=idx; check_data is registered into the snapshot at this clock edge; next state is SEND.
REQ-017 SEND: out_valid=1, out_addr=idx, out_data=snapshot.
REQ-018 Transfer occurs on a clock edge where out_valid=1 and out_ready=1.
REQ-019 Transfer with idx<LAST -> idx+1, CAP; transfer with idx==LAST -> DONE.
REQ-020 out_valid, out_addr and out_data shall remain stable while out_valid=1 and out_ready=0.
REQ-021 DONE asserts done=1 for exactly one cycle, then goes to IDLE.
REQ-022 The first word is presented 2 cycles after start is sampled; each later word 2 cycles after the previous transfer.
REQ-023 start is ignored while busy=1.
REQ-024 abort=1 in CAP or SEND -> IDLE next edge, out_valid=0 next cycle, no done pulse.
REQ-025 abort and a transfer on the same edge: abort wins; the transfer still counts for the consumer.
REQ-026 start and abort together in IDLE: abort wins; the FSM stays in IDLE.
REQ-027 check_addr=idx in CAP and SEND; check_addr=0 in IDLE and DONE.
REQ-028 idx never exceeds LAST; there is no wrap-around within a scan.

Reset
REQ-029 rstn=0 shall force the FSM to IDLE immediately (asynchronously), regardless of clk.
REQ-030 Reset values: idx=0, snapshot=0, check_addr=0, busy=0, out_valid=0, out_addr=0, out_data=0, done=0.
REQ-031 Reset in mid-scan discards the scan; the first cycle after release is IDLE.

Configuration
REQ-032 Macro CHECK_SCAN_HZD_EN defined: LAST=5; the scan covers IF, ID, EX, MEM, WB and HZD (6 words).
REQ-033 Macro CHECK_SCAN_HZD_EN undefined: LAST=4; 5 words; check_addr never equals 5.

Verification
REQ-034 Stimulus: HZD_EN set, out_ready tied 1, mux returns 0x1000_0000+addr, start pulse. Required: 6 words, addr 0..5, data 0x1000_0000..0x1000_0005, one transfer every 2 cycles, then one done pulse.
REQ-035 Stimulus: out_ready=0 for 4 cycles while word addr=2 is presented. Required: out_valid, out_addr=2 and out_data hold constant; the scan resumes after out_ready rises.
REQ-036 Stimulus: abort asserted in SEND of addr=3. Required: IDLE next cycle, out_valid=0, busy=0, no done pulse; a new start restarts at addr 0.
REQ-037 Stimulus: rstn low asynchronously during CAP of addr=1, between clock edges. Required: all outputs 0 immediately; after release, IDLE.
REQ-038 Stimulus: start pulses while busy, plus start and abort together in IDLE. Required: no effect in either case.
REQ-039 Stimulus: HZD_EN undefined, full scan. Required: exactly 5 words (addr 0..4), done after addr 4, check_addr never 5.
